// File: rtl/input_repeat.sv
// Purpose : turns debounced button levels into one-cycle command events with delayed auto-repeat.
// Latency : a rise sampled at edge t is presented (ev_valid=1) during the following cycle.
// Backpr. : events park in a per-channel pending bit until accepted; a second event on a busy channel coalesces and sets overrun.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset (deassertion is used synchronously)
//   enable       event generation allowed; low forces every channel idle and drops pending events
//   btn_in[N]    debounced button levels, 1 = pressed
//   ev_ready     consumer takes the presented event at this edge
//   ev_valid     at least one event is pending
//   ev_id        index of the presented event (lowest pending channel wins)
//   overrun      sticky: an event was merged into one that was already pending
//   clr_overrun  synchronous clear of overrun (a same-cycle new overrun wins)
//
// Build option
//   INPUT_AUTOREPEAT_EN  defined   : per-channel DAS/ARR repeat FSMs and counters are built.
//                        undefined : only press (rising-edge) events fire; DAS_TICK/ARR_TICK unused.

module input_repeat #(
    parameter int N        = 4,
    parameter int DAS_TICK = 8_500_000,
    parameter int ARR_TICK = 2_500_000
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  enable,
    input  logic [N-1:0]                          btn_in,
    input  logic                                  ev_ready,
    output logic                                  ev_valid,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]  ev_id,
    output logic                                  overrun,
    input  logic                                  clr_overrun
);

    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    // Parameter sanity: the repeat timing cannot be expressed below these bounds.
    if (DAS_TICK < 2 || ARR_TICK < 1) begin : g_bad_param
        $error("input_repeat: DAS_TICK must be >= 2 and ARR_TICK >= 1");
    end

    logic [N-1:0]   prev_q;
    logic [N-1:0]   rise;
    logic [N-1:0]   fire;
    logic [N-1:0]   pending_q;
    logic [N-1:0]   pending_d;
    logic [N-1:0]   acc_vec;
    logic           accept;
    logic           ovr_set;
    logic           overrun_q;
    logic           overrun_d;
    logic [IDW-1:0] ev_id_c;

    // ------------------------------------------------------------------
    // Edge detect. prev_q keeps tracking while disabled so a button held
    // across an enable rise does not look like a fresh press.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= btn_in;
        end
    end

    assign rise = btn_in & ~prev_q;

`ifdef INPUT_AUTOREPEAT_EN
    // ------------------------------------------------------------------
    // Per-channel repeat FSM: IDLE -> DELAY (DAS) -> REPEAT (ARR, looping).
    // ------------------------------------------------------------------
    localparam int MAXT = (DAS_TICK > ARR_TICK) ? DAS_TICK : ARR_TICK;
    localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    state_t        state_q [N];
    state_t        state_d [N];
    logic [CW-1:0] cnt_q   [N];
    logic [CW-1:0] cnt_d   [N];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        fire = '0;
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];

            if (!enable || !btn_in[i]) begin
                // Disable and release both dominate any same-cycle expiry.
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
            end else begin
                unique case (state_q[i])
                    ST_IDLE: begin
                        // A held button with no fresh rise (e.g. after enable
                        // went high) stays here until released and re-pressed.
                        if (rise[i]) begin
                            fire[i]    = 1'b1;
                            state_d[i] = ST_DELAY;
                            cnt_d[i]   = '0;
                        end
                    end
                    ST_DELAY: begin
                        if (cnt_q[i] == CW'(DAS_TICK - 1)) begin
                            fire[i]    = 1'b1;
                            state_d[i] = ST_REPEAT;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                    ST_REPEAT: begin
                        // With ARR_TICK=1 the compare is always true: one event per cycle.
                        if (cnt_q[i] == CW'(ARR_TICK - 1)) begin
                            fire[i]  = 1'b1;
                            cnt_d[i] = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end
`else
    // Press-only build: one event per rising edge while enabled.
    assign fire = enable ? rise : '0;
`endif

    // ------------------------------------------------------------------
    // Presentation: lowest pending channel is offered first.
    // ------------------------------------------------------------------
    always_comb begin
        ev_id_c = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                ev_id_c = IDW'(i);
            end
        end
    end

    assign ev_valid = |pending_q;
    assign ev_id    = ev_id_c;
    assign accept   = ev_valid & ev_ready;

    always_comb begin
        acc_vec = '0;
        if (accept) begin
            acc_vec[ev_id_c] = 1'b1;
        end
    end

    // A fire on a channel whose pending bit survives this edge is a coalesce.
    // Fire on the channel being accepted re-arms it cleanly (set wins).
    assign ovr_set = |(fire & pending_q & ~acc_vec);

    always_comb begin
        pending_d = enable ? ((pending_q & ~acc_vec) | fire) : '0;
    end

    always_comb begin
        overrun_d = overrun_q;
        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;

endmodule

// File: tb/tb_input_repeat.sv
// Purpose : directed table plus hand-written sequences for input_repeat (N=4, DAS_TICK=5, ARR_TICK=3).
// Latency : expected outputs are sampled 1 time unit after the edge that consumed each input row.
// Backpr. : ev_ready is driven per row to exercise queuing, coalescing and same-edge accept/fire.

module tb_input_repeat;

    localparam int N   = 4;
    localparam int DAS = 5;
    localparam int ARR = 3;

`ifdef INPUT_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [3:0] btn_in;
    logic       ev_ready;
    logic       ev_valid;
    logic [1:0] ev_id;
    logic       overrun;
    logic       clr_overrun;

    int n_vec = 0;
    int n_bad = 0;

    input_repeat #(
        .N        (N),
        .DAS_TICK (DAS),
        .ARR_TICK (ARR)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .btn_in      (btn_in),
        .ev_ready    (ev_ready),
        .ev_valid    (ev_valid),
        .ev_id       (ev_id),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] btn;
        logic       rdy;
        logic       clr;
        logic       vld;
        logic [1:0] id;
        logic       ovr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic en, input logic [3:0] btn, input logic rdy, input logic clr,
                       input logic vld, input logic [1:0] id, input logic ovr);
        vec_t v;
        v.en  = en;  v.btn = btn; v.rdy = rdy; v.clr = clr;
        v.vld = vld; v.id  = id;  v.ovr = ovr;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ev_id is only meaningful while ev_valid, except where chk_id forces it (reset state).
    task automatic check(input string name, input logic vld, input logic [1:0] id, input logic ovr,
                         input bit chk_id);
        logic bad;
        n_vec++;
        bad = (ev_valid !== vld) || (overrun !== ovr) || ((vld || chk_id) && (ev_id !== id));
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got valid=%b id=%0d overrun=%b, expected valid=%b id=%0d overrun=%b",
                     name, ev_valid, ev_id, overrun, vld, id, ovr);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- table (holds shorter than DAS, so valid in both builds) --------
        //   en   btn      rdy   clr   vld   id    ovr
        add(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0); // 0 idle
        add(1'b1, 4'b0110, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0); // 1 btn1+btn2 together
        add(1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0); // 2 btn1 taken, btn2 next
        add(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0); // 3 queue empty
        add(1'b1, 4'b1000, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0); // 4 tap btn3 ...
        add(1'b1, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0); // 5 ... second cycle, no event
        add(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0); // 6
        add(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0); // 7
        add(1'b1, 4'b1001, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0); // 8 ch0+ch3 held off
        add(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0); // 9
        add(1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0); // 10 ch0 taken, ch3 next
        add(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0); // 11
        add(1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0); // 12 press ch0, not taken
        add(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0); // 13
        add(1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1); // 14 re-press -> coalesce
        add(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1); // 15 single accept, overrun sticky
        add(1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0); // 16 clear overrun
        add(1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0); // 17
        add(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0); // 18
        add(1'b1, 4'b0001, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0); // 19 accept + refire same edge
        add(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0); // 20
        add(1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0); // 21
        add(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0); // 22
        add(1'b1, 4'b0100, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1); // 23 new overrun beats clear
        add(1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0); // 24
        add(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0); // 25 disabled press
        add(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0); // 26
        add(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0); // 27 enable while held
        add(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0); // 28
        add(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0); // 29 release
        add(1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0); // 30 press again
        add(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0); // 31
        add(1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0); // 32 pending ch1
        add(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0); // 33 disable drops it
        add(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0); // 34
        add(1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0); // 35
        add(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0); // 36
        add(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0); // 37

        // ---------------- reset state ----------------
        reset_n     = 1'b0;
        enable      = 1'b0;
        btn_in      = 4'b0000;
        ev_ready    = 1'b1;
        clr_overrun = 1'b0;
        #2;
        check("reset_state", 1'b0, 2'd0, 1'b0, 1'b1);
        tick();
        tick();
        reset_n = 1'b1;
        enable  = 1'b1;
        tick();
        check("post_reset_idle", 1'b0, 2'd0, 1'b0, 1'b1);

        // ---------------- table ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            enable      = tbl[i].en;
            btn_in      = tbl[i].btn;
            ev_ready    = tbl[i].rdy;
            clr_overrun = tbl[i].clr;
            tick();
            check($sformatf("vec%0d", i), tbl[i].vld, tbl[i].id, tbl[i].ovr, 1'b0);
        end
        enable = 1'b1; btn_in = 4'b0000; ev_ready = 1'b1; clr_overrun = 1'b0;

        // ---------------- long hold of btn0: DAS then ARR repeats ----------------
        for (int e = 0; e < 25; e++) begin
            logic exp_v;
            btn_in = (e < 20) ? 4'b0001 : 4'b0000;
            tick();
            exp_v = (e == 0) ||
                    (AR && (e == 5 || e == 8 || e == 11 || e == 14 || e == 17));
            check($sformatf("hold_e%0d", e), exp_v, 2'd0, 1'b0, 1'b0);
        end

        // ---------------- hold with consumer stalled ----------------
        ev_ready = 1'b0;
        btn_in   = 4'b0001;
        for (int e = 0; e < 7; e++) begin
            tick();
            check($sformatf("stall_e%0d", e), 1'b1, 2'd0, AR && (e >= 5), 1'b0);
        end
        ev_ready = 1'b1;
        tick();
        check("stall_accept", 1'b0, 2'd0, AR, 1'b0);
        tick();
        check("stall_next_repeat", AR, 2'd0, AR, 1'b0);
        btn_in = 4'b0000;
        tick();
        check("stall_release", 1'b0, 2'd0, AR, 1'b0);
        clr_overrun = 1'b1;
        tick();
        check("clr_overrun", 1'b0, 2'd0, 1'b0, 1'b0);
        clr_overrun = 1'b0;

        // ---------------- async reset while repeating ----------------
        ev_ready = 1'b0;
        btn_in   = 4'b0001;
        tick();
        btn_in   = 4'b0000;
        tick();
        btn_in   = 4'b0001;
        for (int k = 0; k < 9; k++) tick();
        check("pre_reset_busy", 1'b1, 2'd0, 1'b1, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset", 1'b0, 2'd0, 1'b0, 1'b1);
        btn_in = 4'b0000;
        tick();
        tick();
        reset_n  = 1'b1;
        ev_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("release_quiet%0d", k), 1'b0, 2'd0, 1'b0, 1'b0);
        end

        // ---------------- button held through reset release ----------------
        reset_n = 1'b0;
        btn_in  = 4'b0010;
        tick();
        reset_n = 1'b1;
        tick();
        check("held_at_release", 1'b1, 2'd1, 1'b0, 1'b0);
        btn_in = 4'b0000;
        tick();
        check("held_at_release_done", 1'b0, 2'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/input_repeat.md
# input_repeat

Input-event generator sitting directly upstream of the game control stage. Converts debounced button levels into one-cycle command events with Tetris-style delayed auto-repeat (DAS/ARR). Presents events one at a time over a valid/ready handshake so that no press is silently dropped when several buttons fire together. A sticky flag records coalesced events.

## Interface

- N, 4: number of button channels; channel 0 has highest priority.
- DAS_TICK, 8_500_000: cycles from the initial press event to the first repeat event (170 ms at 50 MHz); must be ≥ 2.
- ARR_TICK, 2_500_000: cycles between successive repeat events (50 ms at 50 MHz); must be ≥ 1.

Ports:

- clk  input  1  system clock.
- reset_n  input  1  reset; asynchronous, active-low.
- enable  input  1  event generation allowed (game running).
- btn_in  input  N  debounced button levels, 1 = pressed.
- ev_ready  input  1  consumer accepts the presented event this cycle.
- ev_valid  output  1  an event is pending.
- ev_id  output  $clog2(N) (min 1)  index of the presented event.
- overrun  output  1  sticky flag: an event was coalesced into an already-pending one.
- clr_overrun  input  1  synchronous clear of overrun.

## Operation

- Per channel: prev_q register holding btn_in from the previous cycle; rise = btn_in & ~prev_q.
- Per channel: 2-bit FSM {IDLE, DELAY, REPEAT} and a counter of width $clog2(max(DAS_TICK, ARR_TICK)).
- Per channel: pending bit.
- IDLE: on rise with enable=1 → fire event, go to DELAY, cnt=0.
- DELAY: cnt++ each cycle. At cnt==DAS_TICK-1 → fire event, go to REPEAT, cnt=0.
- REPEAT: cnt++. At cnt==ARR_TICK-1 → fire event, cnt=0.
- btn_in=0 in any state → IDLE, cnt=0, no event. Release has priority over a same-cycle DAS/ARR expiry.
- "Fire event" sets pending[i]. If pending[i] is already set and not being accepted at that edge, set overrun (the events coalesce into one).
- ev_valid = |pending. ev_id = lowest set index. Both decoded combinationally from registered state.
- Accept on ev_valid & ev_ready at posedge: clears pending[ev_id]. If a new event for the same channel fires at that edge, the set wins and overrun is not raised.
- enable=0: all FSMs forced to IDLE, cnt=0, pending cleared. prev_q keeps tracking btn_in, so a button held across an enable rise produces no event until it is released and pressed again.
- clr_overrun clears overrun. A same-cycle new overrun wins.

## Timing

- Reset (async assert): prev_q=0, FSM=IDLE, cnt=0, pending=0, overrun=0. Hence ev_valid=0, ev_id=0.
- Deassertion is used synchronously. A button already held at reset release produces an event on the first clock edge (prev_q=0).
- Latency: rise sampled at edge t → ev_valid=1 during cycle t+1.
- While held, further events fire at edges t+DAS_TICK, then every ARR_TICK edges.
- ARR_TICK=1: repeat event fires every cycle.
- Events from different channels queue in pending. They are presented in priority order, one accepted per cycle at most.
- Reset asserted mid-repeat clears everything immediately. No event is produced on reset release unless btn_in=1.

## Configuration

- INPUT_AUTOREPEAT_EN defined: behaviour as above.
- INPUT_AUTOREPEAT_EN undefined:
  - DELAY/REPEAT states and counters are not built.
  - Only rise events fire.
  - DAS_TICK and ARR_TICK are ignored.
  - The handshake, priority, enable and overrun rules are unchanged.

## Test plan

Benches use N=4, DAS_TICK=5, ARR_TICK=3, ev_ready=1 unless stated.

- Press btn 0 sampled at edge 10, release sampled at edge 30 → ev_valid with ev_id=0 in cycles 11, 16, 19, 22, 25, 28 only. With INPUT_AUTOREPEAT_EN undefined → cycle 11 only.
- btn 1 and btn 2 rise at the same edge 10 → ev_id=1 in cycle 11, ev_id=2 in cycle 12, ev_valid=0 in cycle 13. Tap btn 3 for 2 cycles → exactly one event.
- ev_ready=0, btn 0 held from edge 10 → ev_valid from cycle 11, overrun=1 from cycle 16. After ev_ready=1 at edge 17 → exactly one accept, ev_valid low in cycle 18.
- Assert clr_overrun at edge 20 → overrun=0 in cycle 21.
- enable=0 with btn 2 pressed → no events. Raise enable while btn 2 is still held → no events. Release, then press again → an event 1 cycle later.
- Assert reset_n=0 asynchronously mid-REPEAT → ev_valid and overrun go to 0 without a clock edge. Release reset with buttons low → no event.
